// File: rtl/sa_result_axis_packer_pkg.sv
// sa_pack_pkg: shared constants and types for the result AXI-Stream packer.
//   DATA_W    width of one systolic-array result
//   LANES     results packed per output word
//   OUT_W     output word width (DATA_W*LANES)
//   STRB_W    byte-strobe width (OUT_W/8)
//   pack_word_t  one FIFO entry {data, strb, last}
//   pack_state_e packing FSM states {FILL, FLUSH}
package sa_pack_pkg;
  localparam int DATA_W    = 8;
  localparam int LANES     = 4;
  localparam int OUT_W     = DATA_W * LANES;
  localparam int STRB_W    = OUT_W / 8;
  localparam int LANE_STRB = DATA_W / 8;

  typedef struct packed {
    logic [OUT_W-1:0]  data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } pack_word_t;

  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} pack_state_e;
endpackage

// File: rtl/sa_result_axis_packer_if.sv
// sa_result_axis_packer_if: AXI-Stream master bus of the packer.
//   tvalid/tready  handshake
//   tdata/tstrb    packed results and per-byte strobes
//   tlast          last word of a result frame
// master = packer side, slave = sink side.
interface sa_result_axis_packer_if;
  import sa_pack_pkg::*;
  logic              tvalid;
  logic              tready;
  logic [OUT_W-1:0]  tdata;
  logic [STRB_W-1:0] tstrb;
  logic              tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/sa_result_axis_packer_fifo.sv
// sa_sync_fifo: first-word fall-through synchronous FIFO.
//   clk, rst_n   clock, async active-low reset (clears contents)
//   push_i/wdata_i  write request; accepted when not full, or full with a pop
//   pop_i        read request; only honoured when not empty
//   rdata_o      head entry (valid whenever !empty_o)
//   full_o, empty_o  derived from an occupancy count register
module sa_sync_fifo
  import sa_pack_pkg::*;
#(
  parameter type T     = pack_word_t,
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q];

  // Storage is reset too so the head (and hence tdata) reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/sa_result_axis_packer.sv
// sa_result_axis_packer: packs LANES consecutive array results into one
// AXI-Stream word, tags the last word of each FRAME_LEN-result frame with
// tlast and buffers words in a FIFO_DEPTH-entry FWFT FIFO.
//   clk, rst_n      clock, async active-low reset
//   valid_i/data_i  raw result stream (no backpressure)
//   m_axis          AXI-Stream master (tvalid/tready/tdata/tstrb/tlast)
//   overflow_o      sticky: a completed word was dropped on a full FIFO
// Optional (macro SA_PACK_STATS_EN):
//   frame_cnt_o     saturating count of tlast handshakes
//   drop_cnt_o      saturating count of dropped words
module sa_result_axis_packer
  import sa_pack_pkg::*;
#(
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic [DATA_W-1:0]       data_i,
  sa_result_axis_packer_if.master m_axis,
  output logic                    overflow_o
`ifdef SA_PACK_STATS_EN
  ,
  output logic [15:0]             frame_cnt_o,
  output logic [15:0]             drop_cnt_o
`endif
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  pack_state_e                    state_q, state_d;
  logic [LW-1:0]                  lane_q, lane_d;
  logic [FW-1:0]                  frm_q, frm_d;
  logic [LANES-1:0][DATA_W-1:0]   pack_q, pack_d;
  logic                           ovf_q, ovf_d;
  logic                           push, eof, done, refuse;
  logic                           fifo_full, fifo_empty;
  pack_word_t                     word, head;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    frm_d   = frm_q;
    pack_d  = pack_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    word    = '0;
    eof     = (frm_q == FW'(FRAME_LEN-1));
    done    = 1'b0;
    if (valid_i) begin
      pack_d[lane_q] = data_i;
      done = (lane_q == LW'(LANES-1)) || eof;
      if (done) begin
        // Only lanes 0..lane_q belong to this word; stale lanes read as 0.
        for (int l = 0; l < LANES; l++) begin
          if (l <= int'(lane_q)) begin
            word.data[l*DATA_W +: DATA_W]       = pack_d[l];
            word.strb[l*LANE_STRB +: LANE_STRB] = '1;
          end
        end
        word.last = eof;
        push      = 1'b1;
        lane_d    = '0;
        frm_d     = eof ? '0 : frm_q + 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
        frm_d  = frm_q + 1'b1;
      end
    end
    // Counters above advance regardless of whether the word is kept, so a
    // drop never shifts frame alignment.
    refuse = push && fifo_full && !m_axis.tready;
    case (state_q)
      FILL:    if (refuse) state_d = FLUSH;
      FLUSH: begin
        ovf_d   = 1'b1;
        state_d = refuse ? FLUSH : FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      lane_q  <= '0;
      frm_q   <= '0;
      pack_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      frm_q   <= frm_d;
      pack_q  <= pack_d;
      ovf_q   <= ovf_d;
    end
  end

  sa_sync_fifo #(.T(pack_word_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (m_axis.tready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = head.data;
  assign m_axis.tstrb  = head.strb;
  assign m_axis.tlast  = head.last;
  assign overflow_o    = ovf_q;

`ifdef SA_PACK_STATS_EN
  logic [15:0] fcnt_q, dcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (m_axis.tvalid && m_axis.tready && m_axis.tlast && fcnt_q != 16'hFFFF)
        fcnt_q <= fcnt_q + 1'b1;
      if (refuse && dcnt_q != 16'hFFFF)
        dcnt_q <= dcnt_q + 1'b1;
    end
  end
  assign frame_cnt_o = fcnt_q;
  assign drop_cnt_o  = dcnt_q;
`endif
endmodule
